gpc_ifu32: RTL and testbench
============================

# gpc_ifu32

Instruction fetch unit for the Gwen Processor Core, directly upstream of the single-cycle core's `inst` input. It takes the core's `pc`, runs one valid/ready request to instruction memory per fetch, waits for the response, and presents the returned word on `inst` with a one-cycle `inst_valid` pulse. Bus errors, response timeouts and (optionally) misaligned PCs are reported as faults instead of delivering an instruction.

## Interface
Parameters:
- `WIDTH`, 32, address/PC width.
- `INST_MAX`, 32, instruction width.
- `PC_START`, 32'h8000_0000, reset value of `mem_addr`.
- `TIMEOUT`, 255, maximum WAIT cycles before a timeout fault (1..255, 8-bit counter).

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  synchronous active-low reset.
- `pc`  in  WIDTH  fetch address from core.
- `fetch`  in  1  fetch request; sampled only while `busy`=0.
- `inst`  out  INST_MAX  last fetched instruction, held between fetches.
- `inst_valid`  out  1  one-cycle pulse: `inst` updated this cycle.
- `busy`  out  1  fetch in progress or drain pending; `fetch` ignored.
- `fault`  out  1  one-cycle pulse: fetch ended without an instruction.
- `fault_cause`  out  2  0 none, 1 bus error, 2 timeout, 3 misaligned; held until next accepted fetch.
- `mem_req_valid`  out  1  request to instruction memory.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_addr`  out  WIDTH  request address, stable while `mem_req_valid`=1.
- `mem_rsp_valid`  in  1  response present.
- `mem_rsp_data`  in  INST_MAX  response word.
- `mem_rsp_err`  in  1  response is an error (qualified by `mem_rsp_valid`).

## Operation
- FSM states: IDLE, REQ, WAIT. `busy` = (state != IDLE) | drain.
- IDLE: on `fetch`=1 and drain=0: latch `pc` into `mem_addr`, clear `fault_cause`, go to REQ. Misaligned case: see Configuration.
- REQ: `mem_req_valid`=1, `mem_addr` held. On `mem_req_valid & mem_req_ready` go to WAIT and clear the timeout counter.
- WAIT: counter +1 per cycle without a response. On `mem_rsp_valid`: if `mem_rsp_err`=0, `inst`<=`mem_rsp_data`, pulse `inst_valid`; if `mem_rsp_err`=1, `inst` unchanged, pulse `fault`, cause 1. Either way go to IDLE.
- Timeout: counter reaching `TIMEOUT` with no response -> pulse `fault`, cause 2, set drain, go to IDLE.
- Drain: while set, the first `mem_rsp_valid` is discarded (no `inst`/`fault` effect) and clears drain. `busy` stays 1 until then.
- A response in the same cycle the counter hits `TIMEOUT` is accepted as a normal response; there is no timeout and no drain.
- `mem_rsp_valid` in IDLE/REQ with drain=0 is ignored.
- Reset (any state, mid-transaction included): state IDLE, drain 0, counter 0, `inst`=32'h0000_0013 (NOP), `inst_valid`=0, `fault`=0, `fault_cause`=0, `mem_req_valid`=0, `mem_addr`=`PC_START`. An outstanding memory response after reset is ignored.

## Timing
- All outputs are registered. Fetch sampled in cycle N -> `mem_req_valid` high in N+1.
- Best case: `mem_req_ready` in N+1 and response in N+2 -> `inst`/`inst_valid` in N+3.
- The memory must not respond in the same cycle as acceptance. The earliest response is the cycle after the handshake.
- Minimum spacing between `inst_valid` pulses is 3 cycles: the next fetch is sampled in the pulse cycle.
- `mem_req_valid` never drops before `mem_req_ready`, and `mem_addr` never changes while it is high.

## Configuration
- `GPC_IFU_ALIGN_CHK_EN` defined: when IDLE samples `fetch` with `pc[1:0]`!=0, the next cycle has `fault`=1, cause 3, and the FSM stays in IDLE with no bus request.
- Not defined: `mem_addr[1:0]` is forced to 0 and the fetch proceeds normally. Cause 3 is never produced.

## Test plan
- Reset then fetch `pc`=32'h8000_0000. Memory ready immediately and responds 32'h0010_0093 the next cycle -> `inst`=32'h0010_0093 with `inst_valid` 3 cycles after `fetch`. Before that fetch, `inst` reads 32'h0000_0013.
- `mem_req_ready` held low 4 cycles -> `mem_req_valid` and `mem_addr` are stable throughout. `inst_valid` arrives 4 cycles later than the best case.
- Response with `mem_rsp_err`=1 -> `fault` pulse, `fault_cause`=1, `inst` unchanged, `inst_valid` never asserted.
- `TIMEOUT`=4 with no response -> `fault` and cause 2 after 4 WAIT cycles, `busy` remains 1. A late response is discarded and then `busy`=0. The next fetch returns its own data.
- `pc`=32'h8000_0002: with `GPC_IFU_ALIGN_CHK_EN` -> cause 3 and no `mem_req_valid`. Without it -> `mem_addr`=32'h8000_0000.
- Reset asserted while in WAIT -> all outputs at reset values the next cycle. A response arriving afterwards has no effect.

Source files
------------

// File: rtl/gpc_ifu32.sv
// gpc_ifu32: instruction fetch unit. Runs one valid/ready memory request per fetch and returns the word or a fault.
// Optional macro GPC_IFU_ALIGN_CHK_EN: fault misaligned PCs (cause 3) instead of fetching from the aligned address.
module gpc_ifu32 #(
    parameter int               WIDTH    = 32,
    parameter int               INST_MAX = 32,
    parameter logic [WIDTH-1:0] PC_START = 32'h8000_0000,
    parameter int               TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    pc,
    input  logic                fetch,
    output logic [INST_MAX-1:0] inst,
    output logic                inst_valid,
    output logic                busy,
    output logic                fault,
    output logic [1:0]          fault_cause,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [WIDTH-1:0]    mem_addr,
    input  logic                mem_rsp_valid,
    input  logic [INST_MAX-1:0] mem_rsp_data,
    input  logic                mem_rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [INST_MAX-1:0] NOP      = INST_MAX'(32'h0000_0013);
    localparam logic [7:0]          CNT_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_BUS   = 2'd1;
    localparam logic [1:0] CAUSE_TMO   = 2'd2;
    localparam logic [1:0] CAUSE_ALIGN = 2'd3;

    state_t              state, state_d;
    logic                drain, drain_d;
    logic [7:0]          cnt, cnt_d;
    logic [INST_MAX-1:0] inst_d;
    logic                inst_valid_d;
    logic                fault_d;
    logic [1:0]          fault_cause_d;
    logic [WIDTH-1:0]    mem_addr_d;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d       = state;
        drain_d       = drain;
        cnt_d         = cnt;
        inst_d        = inst;
        inst_valid_d  = 1'b0;
        fault_d       = 1'b0;
        fault_cause_d = fault_cause;
        mem_addr_d    = mem_addr;

        case (state)
            IDLE: begin
                if (drain) begin
                    // The stale response of a timed-out fetch is swallowed here.
                    if (mem_rsp_valid) drain_d = 1'b0;
                end else if (fetch) begin
`ifdef GPC_IFU_ALIGN_CHK_EN
                    if (pc[1:0] != 2'b00) begin
                        fault_d       = 1'b1;
                        fault_cause_d = CAUSE_ALIGN;
                    end else begin
                        mem_addr_d    = pc;
                        fault_cause_d = CAUSE_NONE;
                        state_d       = REQ;
                    end
`else
                    mem_addr_d    = pc & ~WIDTH'(3);
                    fault_cause_d = CAUSE_NONE;
                    state_d       = REQ;
`endif
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = 8'd0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A response always wins over a timeout expiring in the same cycle.
                if (mem_rsp_valid) begin
                    if (mem_rsp_err) begin
                        fault_d       = 1'b1;
                        fault_cause_d = CAUSE_BUS;
                    end else begin
                        inst_d       = mem_rsp_data;
                        inst_valid_d = 1'b1;
                    end
                    state_d = IDLE;
                end else if (cnt == CNT_LAST) begin
                    fault_d       = 1'b1;
                    fault_cause_d = CAUSE_TMO;
                    drain_d       = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            drain       <= 1'b0;
            cnt         <= 8'd0;
            inst        <= NOP;
            inst_valid  <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= CAUSE_NONE;
            mem_addr    <= PC_START;
        end else begin
            state       <= state_d;
            drain       <= drain_d;
            cnt         <= cnt_d;
            inst        <= inst_d;
            inst_valid  <= inst_valid_d;
            fault       <= fault_d;
            fault_cause <= fault_cause_d;
            mem_addr    <= mem_addr_d;
        end
    end

    assign mem_req_valid = (state == REQ);
    assign busy          = (state != IDLE) | drain;

endmodule

// File: tb/tb_gpc_ifu32.sv
// Bench for gpc_ifu32 (TIMEOUT=4): table of fetch transactions plus hand sequences
// for timeout/drain, misaligned PC and reset during WAIT.
module tb_gpc_ifu32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        fetch;
    logic [31:0] inst;
    logic        inst_valid;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;

    int total = 0;
    int bad   = 0;

    gpc_ifu32 #(
        .WIDTH    (32),
        .INST_MAX (32),
        .PC_START (32'h8000_0000),
        .TIMEOUT  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .fetch         (fetch),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .busy          (busy),
        .fault         (fault),
        .fault_cause   (fault_cause),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int          rdy_dly;
        int          rsp_dly;
        logic        err;
        logic [31:0] data;
        logic [31:0] exp_addr;
        logic [31:0] exp_inst;
        logic        exp_valid;
        logic        exp_fault;
        logic [1:0]  exp_cause;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete fetch with scripted ready/response delays; result expected 3+rdy_dly+rsp_dly cycles after fetch.
    task automatic run_vec(input vec_t v);
        check("idle_busy", busy, 0);
        pc    = v.pc;
        fetch = 1'b1;
        step();
        fetch = 1'b0;
        check("req_valid", mem_req_valid, 1);
        check("req_addr", mem_addr, v.exp_addr);
        for (int i = 0; i < v.rdy_dly; i++) begin
            step();
            check("req_hold_valid", mem_req_valid, 1);
            check("req_hold_addr", mem_addr, v.exp_addr);
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("req_dropped", mem_req_valid, 0);
        for (int i = 0; i < v.rsp_dly; i++) begin
            step();
            check("wait_quiet", {30'd0, inst_valid, fault}, 0);
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_err   = v.err;
        mem_rsp_data  = v.data;
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        check("res_inst_valid", inst_valid, v.exp_valid);
        check("res_fault", fault, v.exp_fault);
        check("res_cause", fault_cause, v.exp_cause);
        check("res_inst", inst, v.exp_inst);
        check("res_busy", busy, 0);
        step();
        check("pulse_end", {30'd0, inst_valid, fault}, 0);
        check("cause_held", fault_cause, v.exp_cause);
        check("inst_held", inst, v.exp_inst);
    endtask

    initial begin
        vec_t v;

        vecs[0] = '{pc: 32'h8000_0000, rdy_dly: 0, rsp_dly: 0, err: 1'b0, data: 32'h0010_0093,
                    exp_addr: 32'h8000_0000, exp_inst: 32'h0010_0093, exp_valid: 1'b1, exp_fault: 1'b0, exp_cause: 2'd0};
        vecs[1] = '{pc: 32'h8000_0004, rdy_dly: 4, rsp_dly: 0, err: 1'b0, data: 32'h0020_0113,
                    exp_addr: 32'h8000_0004, exp_inst: 32'h0020_0113, exp_valid: 1'b1, exp_fault: 1'b0, exp_cause: 2'd0};
        vecs[2] = '{pc: 32'h8000_0008, rdy_dly: 0, rsp_dly: 1, err: 1'b1, data: 32'hDEAD_BEEF,
                    exp_addr: 32'h8000_0008, exp_inst: 32'h0020_0113, exp_valid: 1'b0, exp_fault: 1'b1, exp_cause: 2'd1};
        // Response lands in the 4th WAIT cycle, exactly when the counter expires: accepted normally.
        vecs[3] = '{pc: 32'h8000_000C, rdy_dly: 1, rsp_dly: 3, err: 1'b0, data: 32'h0030_0193,
                    exp_addr: 32'h8000_000C, exp_inst: 32'h0030_0193, exp_valid: 1'b1, exp_fault: 1'b0, exp_cause: 2'd0};

        rst           = 1'b0;
        pc            = 32'h0;
        fetch         = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        mem_rsp_err   = 1'b0;
        step();
        step();
        rst = 1'b1;

        check("rst_inst", inst, 32'h0000_0013);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_fault", fault, 0);
        check("rst_cause", fault_cause, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_addr", mem_addr, 32'h8000_0000);
        check("rst_busy", busy, 0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Timeout: 4 WAIT cycles without a response.
        pc    = 32'h8000_0010;
        fetch = 1'b1;
        step();
        fetch         = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("tmo_wait_fault", fault, 0);
            check("tmo_wait_busy", busy, 1);
            step();
        end
        check("tmo_fault", fault, 1);
        check("tmo_cause", fault_cause, 2);
        check("tmo_busy", busy, 1);
        check("tmo_inst", inst, 32'h0030_0193);
        fetch = 1'b1;
        pc    = 32'h8000_0020;
        step();
        fetch = 1'b0;
        check("drain_fault_end", fault, 0);
        check("drain_ignores_fetch", mem_req_valid, 0);
        check("drain_busy", busy, 1);
        step();
        check("drain_busy2", busy, 1);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0BAD_0BAD;
        step();
        mem_rsp_valid = 1'b0;
        check("drain_discard_valid", inst_valid, 0);
        check("drain_discard_fault", fault, 0);
        check("drain_discard_inst", inst, 32'h0030_0193);
        check("drain_done_busy", busy, 0);
        check("drain_cause_held", fault_cause, 2);
        v = '{pc: 32'h8000_0014, rdy_dly: 0, rsp_dly: 2, err: 1'b0, data: 32'h0050_0293,
              exp_addr: 32'h8000_0014, exp_inst: 32'h0050_0293, exp_valid: 1'b1, exp_fault: 1'b0, exp_cause: 2'd0};
        run_vec(v);

        // Misaligned PC.
`ifdef GPC_IFU_ALIGN_CHK_EN
        pc    = 32'h8000_0002;
        fetch = 1'b1;
        step();
        fetch = 1'b0;
        check("mis_fault", fault, 1);
        check("mis_cause", fault_cause, 3);
        check("mis_no_req", mem_req_valid, 0);
        check("mis_busy", busy, 0);
        step();
        check("mis_fault_end", fault, 0);
        check("mis_cause_held", fault_cause, 3);
        check("mis_no_req2", mem_req_valid, 0);
`else
        v = '{pc: 32'h8000_0002, rdy_dly: 0, rsp_dly: 0, err: 1'b0, data: 32'h0040_0213,
              exp_addr: 32'h8000_0000, exp_inst: 32'h0040_0213, exp_valid: 1'b1, exp_fault: 1'b0, exp_cause: 2'd0};
        run_vec(v);
`endif

        // Reset while in WAIT, then a stale response.
        pc    = 32'h8000_0100;
        fetch = 1'b1;
        step();
        fetch         = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("wrst_in_wait", busy, 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("wrst_inst", inst, 32'h0000_0013);
        check("wrst_inst_valid", inst_valid, 0);
        check("wrst_fault", fault, 0);
        check("wrst_cause", fault_cause, 0);
        check("wrst_req_valid", mem_req_valid, 0);
        check("wrst_addr", mem_addr, 32'h8000_0000);
        check("wrst_busy", busy, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hFFFF_FFFF;
        step();
        mem_rsp_valid = 1'b0;
        check("stale_inst", inst, 32'h0000_0013);
        check("stale_inst_valid", inst_valid, 0);
        check("stale_fault", fault, 0);
        check("stale_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
